// File: rtl/week2_nios2_qsys_0_jtag_debug_host_pkg.sv
// Shared types and default geometry for the virtual-JTAG debug host and its benches.
package week2_nios2_qsys_0_jtag_debug_host_pkg;
  localparam int DEF_DR_WIDTH   = 38;
  localparam int DEF_IR_WIDTH   = 2;
  localparam int DEF_RTI_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI, ST_RSP
  } state_e;

  // Bit counter must reach DR_WIDTH without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/week2_nios2_qsys_0_jtag_debug_host_if.sv
// Command/response channel plus the virtual-JTAG pins; master = the host initiator.
interface week2_nios2_qsys_0_jtag_debug_host_if
  import week2_nios2_qsys_0_jtag_debug_host_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                cmd_ir_only;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic [IR_WIDTH-1:0] vji_ir_out;
  logic                vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic                vji_tdi;
  logic                vji_tdo;

  modport master (
    input  cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, rsp_ready, vji_ir_out, vji_tdo,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, vji_ir_in,
           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, rsp_ready, vji_ir_out, vji_tdo,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, vji_ir_in,
           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi
  );
endinterface

// File: rtl/week2_nios2_qsys_0_jtag_debug_host_dr_shift.sv
// DR shift register (LSB out first, TDO in at MSB) with scan bit counter.
module week2_nios2_qsys_0_jtag_debug_host_dr_shift
  import week2_nios2_qsys_0_jtag_debug_host_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [DR_WIDTH-1:0] load_val,
  input  logic                shift_en,
  input  logic                tdo,
  output logic                tdi,
  output logic [DR_WIDTH-1:0] data,
  output logic                last
);
  localparam int CNT_W = cnt_width(DR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_val;
      cnt  <= '0;
    end else if (shift_en) begin
      data <= {tdo, data[DR_WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_LAST);
  // Bit the pin must carry next cycle: the parent registers it, so look one shift ahead.
  assign tdi  = shift_en ? data[1] : data[0];
endmodule

// File: rtl/week2_nios2_qsys_0_jtag_debug_host.sv
// Virtual-JTAG debug host: one command -> IR update, optional DR scan, RTI, response.
module week2_nios2_qsys_0_jtag_debug_host
  import week2_nios2_qsys_0_jtag_debug_host_pkg::*;
#(
  parameter int DR_WIDTH   = DEF_DR_WIDTH,
  parameter int IR_WIDTH   = DEF_IR_WIDTH,
  parameter int RTI_CYCLES = DEF_RTI_CYCLES
) (
  input logic clk,
  input logic reset_n,
  week2_nios2_qsys_0_jtag_debug_host_if.master bus
);
  localparam int RTI_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
  localparam logic [RTI_W-1:0] RTI_LAST = RTI_W'(RTI_CYCLES - 1);

  state_e              st, st_nxt;
  logic                accept, ir_only, shift_en;
  logic                sr_tdi, sr_last;
  logic [DR_WIDTH-1:0] sr_data, load_val;
  logic [RTI_W-1:0]    rti_cnt;
  logic                cmd_ready_q, rsp_valid_q;
  logic                uir_q, cdr_q, sdr_q, udr_q, rti_q, tdi_q;
  logic [IR_WIDTH-1:0] ir_in_q, ir_out_q;

  assign accept   = cmd_ready_q & bus.cmd_valid;
  assign shift_en = (st == ST_SDR);
  // IR-only commands load zeros so the response DR reads back as 0.
  assign load_val = bus.cmd_ir_only ? '0 : bus.cmd_dr;

  week2_nios2_qsys_0_jtag_debug_host_dr_shift #(.DR_WIDTH(DR_WIDTH)) u_dr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .load_val (load_val),
    .shift_en (shift_en),
    .tdo      (bus.vji_tdo),
    .tdi      (sr_tdi),
    .data     (sr_data),
    .last     (sr_last)
  );

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (accept) st_nxt = ST_UIR;
      ST_UIR:  st_nxt = ir_only ? ST_RTI : ST_CDR;
      ST_CDR:  st_nxt = ST_SDR;
      ST_SDR:  if (sr_last) st_nxt = ST_UDR;
      ST_UDR:  st_nxt = ST_RTI;
      ST_RTI:  if (rti_cnt == RTI_LAST) st_nxt = ST_RSP;
      ST_RSP:  if (bus.rsp_ready) st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  // All pin-facing outputs are decoded from the next state and registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
      tdi_q       <= 1'b0;
      ir_in_q     <= '0;
      ir_out_q    <= '0;
      ir_only     <= 1'b0;
      rti_cnt     <= '0;
    end else begin
      st          <= st_nxt;
      cmd_ready_q <= (st_nxt == ST_IDLE);
      rsp_valid_q <= (st_nxt == ST_RSP);
      uir_q       <= (st_nxt == ST_UIR);
      cdr_q       <= (st_nxt == ST_CDR);
      sdr_q       <= (st_nxt == ST_SDR);
      udr_q       <= (st_nxt == ST_UDR);
      rti_q       <= (st_nxt == ST_RTI);
      tdi_q       <= (st_nxt == ST_SDR) & sr_tdi;
      rti_cnt     <= (st == ST_RTI) ? rti_cnt + RTI_W'(1) : '0;
      if (accept) begin
        ir_in_q <= bus.cmd_ir;
        ir_only <= bus.cmd_ir_only;
      end
      if (st == ST_UIR) ir_out_q <= bus.vji_ir_out;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_dr     = sr_data;
  assign bus.rsp_ir_out = ir_out_q;
  assign bus.vji_ir_in  = ir_in_q;
  assign bus.vji_uir    = uir_q;
  assign bus.vji_cdr    = cdr_q;
  assign bus.vji_sdr    = sdr_q;
  assign bus.vji_udr    = udr_q;
  assign bus.vji_rti    = rti_q;
  assign bus.vji_tdi    = tdi_q;
endmodule

// File: tb/tb_week2_nios2_qsys_0_jtag_debug_host.sv
// Directed bench for the virtual-JTAG debug host with hand-computed expectations.
module tb_week2_nios2_qsys_0_jtag_debug_host;
  import week2_nios2_qsys_0_jtag_debug_host_pkg::*;
  localparam int DW = DEF_DR_WIDTH;
  localparam int IW = DEF_IR_WIDTH;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  week2_nios2_qsys_0_jtag_debug_host_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) bus ();

  week2_nios2_qsys_0_jtag_debug_host #(.DR_WIDTH(DW), .IR_WIDTH(IW), .RTI_CYCLES(1)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic loop_en = 1'b0;
  logic tdo_val = 1'b0;
  assign bus.vji_tdo = loop_en ? bus.vji_tdi : tdo_val;

  int checks = 0;
  int errors = 0;

  logic [4:0]    trc [0:199];   // {rti,udr,sdr,cdr,uir} per cycle after accept
  logic          tdi_trc [0:199];
  int            rsp_cyc;
  logic [DW-1:0] got_dr;
  logic [IW-1:0] got_ir;

  // Offer a command and return in cycle 1 (just after the accept edge).
  task automatic issue(input logic [IW-1:0] ir, input logic [DW-1:0] dr, input logic ir_only);
    int n;
    n = 0;
    bus.cmd_ir = ir; bus.cmd_dr = dr; bus.cmd_ir_only = ir_only; bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Trace strobes from cycle 1 until rsp_valid (bounded); rsp_cyc = -1 on timeout.
  task automatic collect();
    rsp_cyc = -1;
    for (int c = 1; c < 200; c++) begin
      trc[c] = {bus.vji_rti, bus.vji_udr, bus.vji_sdr, bus.vji_cdr, bus.vji_uir};
      tdi_trc[c] = bus.vji_tdi;
      if (bus.rsp_valid) begin
        rsp_cyc = c; got_dr = bus.rsp_dr; got_ir = bus.rsp_ir_out;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus.cmd_ready, bus.rsp_valid} !== 2'b00) begin errors++;
      $display("FAIL reset_handshake got %b want 00", {bus.cmd_ready, bus.rsp_valid}); end
    checks++; if ({bus.rsp_dr, bus.rsp_ir_out, bus.vji_ir_in} !== '0) begin errors++;
      $display("FAIL reset_data got %h/%h/%h want 0", bus.rsp_dr, bus.rsp_ir_out, bus.vji_ir_in); end
    checks++; if ({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti, bus.vji_tdi} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 000000",
        {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti, bus.vji_tdi}); end
    reset_n = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++;
      $display("FAIL ready_before_edge got %b want 0", bus.cmd_ready); end
    @(posedge clk); #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++;
      $display("FAIL ready_after_release got %b want 1", bus.cmd_ready); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if ({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti, bus.vji_tdi, bus.rsp_valid} != 7'b0
          || bus.cmd_ready !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL idle_quiet got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_tdo_ones();
    logic [7:0] first8;
    int ones_after, sdr_n;
    loop_en = 1'b0; tdo_val = 1'b1;
    issue(2'b01, 38'h00_0000_00A5, 1'b0);
    collect();
    for (int i = 0; i < 8; i++) first8[i] = tdi_trc[3 + i];
    ones_after = 0; sdr_n = 0;
    for (int c = 11; c <= 40; c++) if (tdi_trc[c]) ones_after++;
    for (int c = 1; c < 43; c++) if (trc[c][2]) sdr_n++;
    // Expected pin order 1,0,1,0,0,1,0,1 packed with the first bit at bit 0.
    checks++; if (first8 !== 8'b1010_0101) begin errors++;
      $display("FAIL tdi_first8 got %b want 10100101", first8); end
    checks++; if (ones_after !== 0) begin errors++;
      $display("FAIL tdi_tail got %0d ones want 0", ones_after); end
    checks++; if (sdr_n !== 38) begin errors++;
      $display("FAIL sdr_count got %0d want 38", sdr_n); end
    checks++; if (got_dr !== 38'h3F_FFFF_FFFF) begin errors++;
      $display("FAIL ones_rsp_dr got %h want 3fffffffff", got_dr); end
    checks++; if (rsp_cyc !== 43) begin errors++;
      $display("FAIL ones_rsp_cycle got %0d want 43", rsp_cyc); end
    checks++; if (bus.vji_ir_in !== 2'b01) begin errors++;
      $display("FAIL ones_ir_in got %b want 01", bus.vji_ir_in); end
    consume();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++;
      $display("FAIL rsp_drop got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_loopback();
    int bad;
    logic [4:0] exp;
    loop_en = 1'b1;
    issue(2'b10, 38'h25_5AA5_C33C, 1'b0);
    collect();
    bad = 0;
    for (int c = 1; c <= 42; c++) begin
      if (c == 1) exp = 5'b00001;
      else if (c == 2) exp = 5'b00010;
      else if (c <= 40) exp = 5'b00100;
      else if (c == 41) exp = 5'b01000;
      else exp = 5'b10000;
      if (trc[c] !== exp) bad++;
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL strobe_order got %0d bad cycles want 0", bad); end
    checks++; if (got_dr !== 38'h25_5AA5_C33C) begin errors++;
      $display("FAIL loop_rsp_dr got %h want 255aa5c33c", got_dr); end
    checks++; if (rsp_cyc !== 43) begin errors++;
      $display("FAIL loop_rsp_cycle got %0d want 43", rsp_cyc); end
    consume();
    loop_en = 1'b0;
  endtask

  task automatic test_ir_only();
    tdo_val = 1'b1;
    bus.vji_ir_out = 2'b10;
    issue(2'b11, 38'h3F_0000_1234, 1'b1);
    checks++; if (bus.vji_ir_in !== 2'b11) begin errors++;
      $display("FAIL iro_ir_in got %b want 11", bus.vji_ir_in); end
    collect();
    checks++; if (trc[1] !== 5'b00001 || trc[2] !== 5'b10000) begin errors++;
      $display("FAIL iro_strobes got %b,%b want 00001,10000", trc[1], trc[2]); end
    checks++; if (rsp_cyc !== 3) begin errors++;
      $display("FAIL iro_rsp_cycle got %0d want 3", rsp_cyc); end
    checks++; if (got_ir !== 2'b10) begin errors++;
      $display("FAIL iro_ir_out got %b want 10", got_ir); end
    checks++; if (got_dr !== 38'h0) begin errors++;
      $display("FAIL iro_rsp_dr got %h want 0", got_dr); end
    consume();
  endtask

  task automatic test_back_to_back();
    int bad;
    tdo_val = 1'b1;
    bus.vji_ir_out = 2'b01;
    issue(2'b01, 38'h12_3456_789A, 1'b0);
    collect();
    bus.cmd_ir = 2'b10; bus.cmd_ir_only = 1'b1; bus.cmd_valid = 1'b1;
    bus.vji_ir_out = 2'b11;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_dr !== 38'h3F_FFFF_FFFF || bus.rsp_ir_out !== 2'b01
          || bus.cmd_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++; if ({bus.cmd_ready, bus.rsp_valid, bus.vji_uir} !== 3'b100) begin errors++;
      $display("FAIL idle_gap got %b want 100", {bus.cmd_ready, bus.rsp_valid, bus.vji_uir}); end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.vji_uir, bus.cmd_ready, bus.vji_ir_in} !== 4'b10_10) begin errors++;
      $display("FAIL next_accept got %b want 1010", {bus.vji_uir, bus.cmd_ready, bus.vji_ir_in}); end
    collect();
    checks++; if (rsp_cyc !== 3 || got_ir !== 2'b11) begin errors++;
      $display("FAIL b2b_rsp got cyc %0d ir %b want cyc 3 ir 11", rsp_cyc, got_ir); end
    consume();
  endtask

  task automatic test_reset_mid();
    loop_en = 1'b1;
    issue(2'b01, 38'h15_5555_AAAA, 1'b0);
    for (int c = 1; c < 20; c++) begin @(posedge clk); #1; end
    checks++; if (bus.vji_sdr !== 1'b1) begin errors++;
      $display("FAIL mid_sdr_active got %b want 1", bus.vji_sdr); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti, bus.vji_tdi} !== 6'b0) begin
      errors++; $display("FAIL async_drop got %b want 000000",
        {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti, bus.vji_tdi}); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b00) begin errors++;
      $display("FAIL mid_no_rsp got %b want 00", {bus.rsp_valid, bus.cmd_ready}); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++;
      $display("FAIL mid_ready got %b want 1", bus.cmd_ready); end
    issue(2'b10, 38'h2A_BCDE_F012, 1'b0);
    collect();
    checks++; if (got_dr !== 38'h2A_BCDE_F012 || rsp_cyc !== 43) begin errors++;
      $display("FAIL mid_recover got %h at %0d want 2abcdef012 at 43", got_dr, rsp_cyc); end
    consume();
    loop_en = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_dr = '0; bus.cmd_ir_only = 1'b0;
    bus.rsp_ready = 1'b0; bus.vji_ir_out = '0;
    test_reset();
    test_tdo_ones();
    test_loopback();
    test_ir_only();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
